// File: rtl/qsn_pkg.sv
// rtl/qsn_pkg.sv - Shared constants, types and shift-to-select mapping for the Pc=3 QSN feeder
package qsn_pkg;

    localparam int Z       = 3;
    localparam int QSN_LAT = 2;

    typedef logic [Z-1:0] plane_t;

    typedef struct packed {
        logic [1:0] left;
        logic [1:0] right;
        logic [1:0] merge;
    } qsn_sel_t;

    localparam qsn_sel_t SEL_S0 = {2'd0, 2'd0, 2'b00};
    localparam qsn_sel_t SEL_S1 = {2'd1, 2'd2, 2'b11};
    localparam qsn_sel_t SEL_S2 = {2'd2, 2'd1, 2'b01};

    // Shift 3 has no legal meaning for Z=3; it falls back to the identity selects.
    function automatic qsn_sel_t shift_to_sel(input logic [1:0] shift);
        qsn_sel_t sel;
        case (shift)
            2'd1:    sel = SEL_S1;
            2'd2:    sel = SEL_S2;
            default: sel = SEL_S0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/qsn_out_fifo.sv
// rtl/qsn_out_fifo.sv - First-word fall-through FIFO that absorbs QSN results under downstream backpressure
module qsn_out_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int W          = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic         o_valid,
    output logic [W-1:0] o_rd_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [FIFO_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_wr;
    logic w_do_rd;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_rd = i_rd_en && !w_empty;
    // A write into a full FIFO is only allowed when the head leaves on the same edge.
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_valid   = !w_empty;
    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/qsn_feed_ctrl_len3.sv
// rtl/qsn_feed_ctrl_len3.sv - Credit-based feeder and output buffer for the Z=3 QSN; QSN_FEED_SHIFT_CHK_EN adds err_shift
module qsn_feed_ctrl_len3 #(
    parameter int Z          = qsn_pkg::Z,
    parameter int QSN_LAT    = qsn_pkg::QSN_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         sys_clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_shift,
    input  logic [Z-1:0] in_bit0,
    input  logic [Z-1:0] in_bit1,
    input  logic [Z-1:0] in_bit2,
    input  logic [Z-1:0] in_bit3,
    output logic [Z-1:0] qsn_in_bit0,
    output logic [Z-1:0] qsn_in_bit1,
    output logic [Z-1:0] qsn_in_bit2,
    output logic [Z-1:0] qsn_in_bit3,
    output logic [1:0]   left_sel,
    output logic [1:0]   right_sel,
    output logic [1:0]   merge_sel,
    input  logic [Z-1:0] qsn_out_bit0,
    input  logic [Z-1:0] qsn_out_bit1,
    input  logic [Z-1:0] qsn_out_bit2,
    input  logic [Z-1:0] qsn_out_bit3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [Z-1:0] out_bit0,
    output logic [Z-1:0] out_bit1,
    output logic [Z-1:0] out_bit2,
    output logic [Z-1:0] out_bit3
`ifdef QSN_FEED_SHIFT_CHK_EN
    ,
    output logic         err_shift
`endif
);

    import qsn_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int W  = 4 * Z;
    localparam logic [CW-1:0] CREDIT_INIT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);

    logic              r_live;
    logic [CW-1:0]     r_credit;
    logic [QSN_LAT:0]  r_vpipe;
    logic [Z-1:0]      r_qsn_in0;
    logic [Z-1:0]      r_qsn_in1;
    logic [Z-1:0]      r_qsn_in2;
    logic [Z-1:0]      r_qsn_in3;
    qsn_sel_t          r_sel;

    logic              w_acc;
    logic              w_bad;
    logic              w_take;
    logic              w_pop;
    logic              w_fifo_wr;
    logic              w_fifo_valid;
    logic [W-1:0]      w_fifo_wdata;
    logic [W-1:0]      w_fifo_rdata;
    qsn_sel_t          w_sel;

    // r_live keeps in_ready low during reset even though the credit resets full.
    assign in_ready = r_live && (r_credit != '0);
    assign w_acc    = in_valid && in_ready;

`ifdef QSN_FEED_SHIFT_CHK_EN
    logic r_err_shift;

    assign w_bad     = w_acc && (in_shift == 2'd3);
    assign err_shift = r_err_shift;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_err_shift <= 1'b0;
        end else if (w_bad) begin
            r_err_shift <= 1'b1;
        end
    end
`else
    assign w_bad = 1'b0;
`endif

    // An illegal word is consumed but never enters the QSN or the credit loop.
    assign w_take = w_acc && !w_bad;
    assign w_sel  = shift_to_sel(in_shift);
    assign w_pop  = w_fifo_valid && out_ready;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_live   <= 1'b0;
            r_credit <= CREDIT_INIT;
            r_vpipe  <= '0;
        end else begin
            r_live  <= 1'b1;
            r_vpipe <= {r_vpipe[QSN_LAT-1:0], w_take};
            case ({w_take, w_pop})
                2'b10:   r_credit <= r_credit - CREDIT_ONE;
                2'b01:   r_credit <= r_credit + CREDIT_ONE;
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_qsn_in0 <= '0;
            r_qsn_in1 <= '0;
            r_qsn_in2 <= '0;
            r_qsn_in3 <= '0;
            r_sel     <= SEL_S0;
        end else if (w_take) begin
            r_qsn_in0 <= in_bit0;
            r_qsn_in1 <= in_bit1;
            r_qsn_in2 <= in_bit2;
            r_qsn_in3 <= in_bit3;
            r_sel     <= w_sel;
        end
    end

    assign qsn_in_bit0 = r_qsn_in0;
    assign qsn_in_bit1 = r_qsn_in1;
    assign qsn_in_bit2 = r_qsn_in2;
    assign qsn_in_bit3 = r_qsn_in3;
    assign left_sel    = r_sel.left;
    assign right_sel   = r_sel.right;
    assign merge_sel   = r_sel.merge;

    // The last valid stage lines up with the QSN's registered result.
    assign w_fifo_wr    = r_vpipe[QSN_LAT];
    assign w_fifo_wdata = {qsn_out_bit3, qsn_out_bit2, qsn_out_bit1, qsn_out_bit0};

    qsn_out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .W          (W)
    ) u_fifo (
        .i_clk     (sys_clk),
        .i_rst_n   (rstn),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_fifo_wdata),
        .i_rd_en   (out_ready),
        .o_valid   (w_fifo_valid),
        .o_rd_data (w_fifo_rdata)
    );

    assign out_valid = w_fifo_valid;
    assign {out_bit3, out_bit2, out_bit1, out_bit0} = w_fifo_rdata;

endmodule

// File: tb/tb_qsn_feed_ctrl_len3.sv
// tb/tb_qsn_feed_ctrl_len3.sv - Directed self-checking bench for qsn_feed_ctrl_len3 with a 2-stage QSN stand-in
module tb_qsn_feed_ctrl_len3;

    logic       sys_clk = 1'b0;
    logic       rstn    = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] in_shift = 2'd0;
    logic [2:0] in_bit0 = '0, in_bit1 = '0, in_bit2 = '0, in_bit3 = '0;
    logic [2:0] qsn_in_bit0, qsn_in_bit1, qsn_in_bit2, qsn_in_bit3;
    logic [2:0] qsn_out_bit0, qsn_out_bit1, qsn_out_bit2, qsn_out_bit3;
    logic [2:0] out_bit0, out_bit1, out_bit2, out_bit3;
    logic [1:0] left_sel, right_sel, merge_sel;
    logic       in_ready, out_valid;
`ifdef QSN_FEED_SHIFT_CHK_EN
    logic       err_shift;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pops   = 0;
    logic [11:0] exp_q [$];

    always #5 sys_clk = ~sys_clk;

    qsn_feed_ctrl_len3 dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_shift     (in_shift),
        .in_bit0      (in_bit0),
        .in_bit1      (in_bit1),
        .in_bit2      (in_bit2),
        .in_bit3      (in_bit3),
        .qsn_in_bit0  (qsn_in_bit0),
        .qsn_in_bit1  (qsn_in_bit1),
        .qsn_in_bit2  (qsn_in_bit2),
        .qsn_in_bit3  (qsn_in_bit3),
        .left_sel     (left_sel),
        .right_sel    (right_sel),
        .merge_sel    (merge_sel),
        .qsn_out_bit0 (qsn_out_bit0),
        .qsn_out_bit1 (qsn_out_bit1),
        .qsn_out_bit2 (qsn_out_bit2),
        .qsn_out_bit3 (qsn_out_bit3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bit0     (out_bit0),
        .out_bit1     (out_bit1),
        .out_bit2     (out_bit2),
        .out_bit3     (out_bit3)
`ifdef QSN_FEED_SHIFT_CHK_EN
        ,
        .err_shift    (err_shift)
`endif
    );

    function automatic logic [2:0] rot3(input logic [2:0] x, input logic [1:0] s);
        logic [2:0] r;
        case (s)
            2'd1:    r = {x[1:0], x[2]};
            2'd2:    r = {x[0], x[2:1]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [11:0] rot12(input logic [11:0] w, input logic [1:0] s);
        return {rot3(w[11:9], s), rot3(w[8:6], s), rot3(w[5:3], s), rot3(w[2:0], s)};
    endfunction

    function automatic logic [11:0] mkword(input int i);
        return 12'(i * 2487 + 451);
    endfunction

    // QSN stand-in: rotate every plane by left_sel, two register stages.
    logic [11:0] q_s1 = '0, q_s2 = '0;
    always @(posedge sys_clk) begin
        q_s1 <= rot12({qsn_in_bit3, qsn_in_bit2, qsn_in_bit1, qsn_in_bit0}, left_sel);
        q_s2 <= q_s1;
    end
    assign {qsn_out_bit3, qsn_out_bit2, qsn_out_bit1, qsn_out_bit0} = q_s2;

    always @(negedge sys_clk) begin
        if (rstn && dut.u_fifo.w_full && dut.w_fifo_wr && !dut.w_pop) begin
            errors++;
            $display("FAIL fifo_overflow write into full FIFO at cycle %0d", cyc);
        end
    end

    task automatic tick(input logic v, input logic [1:0] sh, input logic [11:0] w, input logic r);
        int exp_c;
        logic [11:0] e;
        logic [11:0] head;
        @(negedge sys_clk);
        cyc++;
        if (rstn) begin
            exp_c = 4 - exp_q.size();
            checks++;
            if (int'(dut.r_credit) !== exp_c) begin
                errors++;
                $display("FAIL credit cycle %0d got=%0d exp=%0d", cyc, dut.r_credit, exp_c);
            end
        end
        in_valid  = v;
        in_shift  = sh;
        {in_bit3, in_bit2, in_bit1, in_bit0} = w;
        out_ready = r;
        head = {out_bit3, out_bit2, out_bit1, out_bit0};
        if (out_valid && out_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cycle %0d got=%h exp=none", cyc, head);
            end else begin
                e = exp_q.pop_front();
                if (head !== e) begin
                    errors++;
                    $display("FAIL out_data cycle %0d got=%h exp=%h", cyc, head, e);
                end
            end
        end
        if (in_valid && in_ready) begin
`ifdef QSN_FEED_SHIFT_CHK_EN
            if (sh != 2'd3) exp_q.push_back(rot12(w, sh));
`else
            exp_q.push_back(rot12(w, (sh == 2'd3) ? 2'd0 : sh));
`endif
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) tick(1'b0, 2'd0, 12'h000, 1'b1);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain left=%0d out_valid=%b exp left=0 out_valid=0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid);
        end
        checks++;
        if ({out_bit3, out_bit2, out_bit1, out_bit0, qsn_in_bit3, qsn_in_bit2, qsn_in_bit1, qsn_in_bit0} !== 24'h0 ||
            {left_sel, right_sel, merge_sel} !== 6'h0) begin
            errors++;
            $display("FAIL reset_regs got out=%h qsn_in=%h sel=%h exp 0",
                     {out_bit3, out_bit2, out_bit1, out_bit0},
                     {qsn_in_bit3, qsn_in_bit2, qsn_in_bit1, qsn_in_bit0},
                     {left_sel, right_sel, merge_sel});
        end
`ifdef QSN_FEED_SHIFT_CHK_EN
        checks++;
        if (err_shift !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got=%b exp=0", err_shift);
        end
`endif
        rstn = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 2'd1, 12'h001, 1'b1);
        tick(1'b0, 2'd0, 12'h000, 1'b1);
        checks++;
        if (left_sel !== 2'd1 || right_sel !== 2'd2 || merge_sel !== 2'b11 || qsn_in_bit0 !== 3'b001) begin
            errors++;
            $display("FAIL single_sel got l=%0d r=%0d m=%b q0=%b exp 1 2 11 001",
                     left_sel, right_sel, merge_sel, qsn_in_bit0);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 2'd0, 12'h000, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_early step %0d got out_valid=%b exp=0", i, out_valid);
            end
        end
        tick(1'b0, 2'd0, 12'h000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_bit0 !== 3'b010) begin
            errors++;
            $display("FAIL single_latency got valid=%b bit0=%b exp 1 010", out_valid, out_bit0);
        end
        tick(1'b0, 2'd0, 12'h000, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got out_valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int t = 0;
        int p0 = pops;
        while (k < 8 && t < 20) begin
            tick(1'b1, 2'(k % 3), mkword(k), 1'b1);
            if (in_ready) k++;
            t++;
        end
        // Four words fill the credit loop before the first pop returns one, so one bubble.
        checks++;
        if (k != 8 || t != 9) begin
            errors++;
            $display("FAIL b2b_accept got accepted=%0d cycles=%0d exp 8 9", k, t);
        end
        drain();
        checks++;
        if (pops - p0 != 8) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=8", pops - p0);
        end
    endtask

    task automatic test_backpressure();
        int a = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 2'(k % 3), mkword(20 + k), 1'b0);
            if (in_ready) a++;
            if (k == 4) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_drop got in_ready=%b exp=0", in_ready);
                end
            end
        end
        checks++;
        if (a != 4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_accepts got=%0d in_ready=%b out_valid=%b exp 4 0 1", a, in_ready, out_valid);
        end
        tick(1'b0, 2'd0, 12'h000, 1'b1);
        tick(1'b0, 2'd0, 12'h000, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || {out_bit3, out_bit2, out_bit1, out_bit0} !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_recover got in_ready=%b head=%h exp 1 %h",
                     in_ready, {out_bit3, out_bit2, out_bit1, out_bit0}, exp_q[0]);
        end
    endtask

    task automatic test_full_pop_accept();
        tick(1'b1, 2'd2, mkword(40), 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 12'h000, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() != 4) begin
            errors++;
            $display("FAIL full_state got in_ready=%b out_valid=%b pending=%0d exp 0 1 4",
                     in_ready, out_valid, exp_q.size());
        end
        tick(1'b0, 2'd0, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 2'(i), mkword(41 + i), 1'b1);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_overlap step %0d got in_ready=%b out_valid=%b exp 1 1", i, in_ready, out_valid);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) tick(1'b1, 2'(k % 3), mkword(60 + k), 1'b0);
        tick(1'b0, 2'd0, 12'h000, 1'b0);
        tick(1'b0, 2'd0, 12'h000, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefill got out_valid=%b exp=1", out_valid);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || {out_bit3, out_bit2, out_bit1, out_bit0} !== 12'h0 ||
            qsn_in_bit0 !== 3'b000 || {left_sel, right_sel, merge_sel} !== 6'h0) begin
            errors++;
            $display("FAIL mid_reset got out_valid=%b in_ready=%b head=%h q0=%b sel=%h exp all 0",
                     out_valid, in_ready, {out_bit3, out_bit2, out_bit1, out_bit0}, qsn_in_bit0,
                     {left_sel, right_sel, merge_sel});
        end
        exp_q.delete();
        @(negedge sys_clk);
        rstn = 1'b1;
        tick(1'b0, 2'd0, 12'h000, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release got in_ready=%b exp=1", in_ready);
        end
        drain();
    endtask

    task automatic test_shift3();
        logic [11:0] wa = 12'h5A3;
        logic [11:0] wb = 12'h3C6;
        tick(1'b1, 2'd2, wa, 1'b1);
        tick(1'b1, 2'd3, wb, 1'b1);
        tick(1'b0, 2'd0, 12'h000, 1'b1);
`ifdef QSN_FEED_SHIFT_CHK_EN
        checks++;
        if (err_shift !== 1'b1) begin
            errors++;
            $display("FAIL shift3_err got=%b exp=1", err_shift);
        end
        checks++;
        if (left_sel !== 2'd2 || right_sel !== 2'd1 || merge_sel !== 2'b01 || qsn_in_bit0 !== wa[2:0]) begin
            errors++;
            $display("FAIL shift3_hold got l=%0d r=%0d m=%b q0=%b exp 2 1 01 %b",
                     left_sel, right_sel, merge_sel, qsn_in_bit0, wa[2:0]);
        end
`else
        checks++;
        if (left_sel !== 2'd0 || right_sel !== 2'd0 || merge_sel !== 2'b00 || qsn_in_bit0 !== wb[2:0]) begin
            errors++;
            $display("FAIL shift3_as_s0 got l=%0d r=%0d m=%b q0=%b exp 0 0 00 %b",
                     left_sel, right_sel, merge_sel, qsn_in_bit0, wb[2:0]);
        end
`endif
        drain();
`ifdef QSN_FEED_SHIFT_CHK_EN
        checks++;
        if (err_shift !== 1'b1) begin
            errors++;
            $display("FAIL shift3_sticky got=%b exp=1", err_shift);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_pop_accept();
        test_reset_mid();
        test_shift3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
